// File: rtl/sum_accumulator_if.sv
// Handshake bundle for sum_accumulator: sample stream in, frame result out.
// slave = accumulator side, master = producer/consumer side.
interface sum_accumulator_if #(
  parameter int BITWIDTH = 8,
  parameter int COUNT_W  = 8,
  parameter int GUARD    = 8
);
  localparam int ACC_W = BITWIDTH + 1 + GUARD;

  logic                in_valid;
  logic                in_ready;
  logic [BITWIDTH-1:0] in_sum;
  logic                in_carry;
  logic [COUNT_W-1:0]  in_len;
  logic                out_valid;
  logic                out_ready;
  logic [ACC_W-1:0]    out_acc;
  logic [COUNT_W-1:0]  out_count;
  logic                out_ovf;

  modport slave (
    input  in_valid, in_sum, in_carry, in_len, out_ready,
    output in_ready, out_valid, out_acc, out_count, out_ovf
  );

  modport master (
    output in_valid, in_sum, in_carry, in_len, out_ready,
    input  in_ready, out_valid, out_acc, out_count, out_ovf
  );
endinterface

// File: rtl/sum_accumulator.sv
// Frame accumulator for {carry,sum} adder results; ports: clk, rst (sync,
// active-high), flush, bus (sum_accumulator_if.slave). SUM_ACC_SATURATE_EN: saturate.
module sum_accumulator #(
  parameter int BITWIDTH = 8,
  parameter int COUNT_W  = 8,
  parameter int GUARD    = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  sum_accumulator_if.slave    bus
);
  localparam int ACC_W = BITWIDTH + 1 + GUARD;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic [COUNT_W-1:0] len_q, len_d;
  logic               ovf_q, ovf_d;

  logic               in_ready;
  logic               accept;
  logic [ACC_W-1:0]   sample;
  logic [ACC_W:0]     sum_ext;
  logic [COUNT_W-1:0] count_inc;
  logic [COUNT_W-1:0] len_eff;

  assign in_ready  = (state_q != HOLD) & ~rst & ~flush;
  assign accept    = bus.in_valid & in_ready;
  assign sample    = ACC_W'({bus.in_carry, bus.in_sum});
  assign sum_ext   = {1'b0, acc_q} + {1'b0, sample};
  assign count_inc = count_q + COUNT_W'(1);
  // A zero length frame behaves as a single-sample frame.
  assign len_eff   = (bus.in_len == '0) ? COUNT_W'(1) : bus.in_len;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    count_d = count_q;
    len_d   = len_q;
    ovf_d   = ovf_q;
    if (flush) begin
      state_d = IDLE;
      acc_d   = '0;
      count_d = '0;
      ovf_d   = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            acc_d   = sample;
            count_d = COUNT_W'(1);
            len_d   = len_eff;
            ovf_d   = 1'b0;
            state_d = (len_eff == COUNT_W'(1)) ? HOLD : ACCUM;
          end
        end
        ACCUM: begin
          if (accept) begin
`ifdef SUM_ACC_SATURATE_EN
            // Once pinned at all-ones any further non-zero sample
            // carries again, so the value stays pinned.
            acc_d = sum_ext[ACC_W] ? '1 : sum_ext[ACC_W-1:0];
`else
            acc_d = sum_ext[ACC_W-1:0];
`endif
            ovf_d   = ovf_q | sum_ext[ACC_W];
            count_d = count_inc;
            if (count_inc == len_q) state_d = HOLD;
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            state_d = IDLE;
            acc_d   = '0;
            count_d = '0;
            ovf_d   = 1'b0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      count_q <= '0;
      len_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      count_q <= count_d;
      len_q   <= len_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = (state_q == HOLD);
  assign bus.out_acc   = acc_q;
  assign bus.out_count = count_q;
  assign bus.out_ovf   = ovf_q;
endmodule

// File: tb/tb_sum_accumulator.sv
// Bench for sum_accumulator: two instances (GUARD=8 and GUARD=0) share stimulus;
// table frames, hand sequences and random frames vs an arithmetic model.
module tb_sum_accumulator;
  logic clk = 1'b0;
  logic rst, flush;
  logic in_valid, in_carry, out_ready;
  logic [7:0] in_sum, in_len;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  sum_accumulator_if #(.BITWIDTH(8), .COUNT_W(8), .GUARD(8)) ua ();
  sum_accumulator_if #(.BITWIDTH(8), .COUNT_W(8), .GUARD(0)) ub ();

  assign ua.in_valid  = in_valid;
  assign ua.in_sum    = in_sum;
  assign ua.in_carry  = in_carry;
  assign ua.in_len    = in_len;
  assign ua.out_ready = out_ready;
  assign ub.in_valid  = in_valid;
  assign ub.in_sum    = in_sum;
  assign ub.in_carry  = in_carry;
  assign ub.in_len    = in_len;
  assign ub.out_ready = out_ready;

  sum_accumulator #(.BITWIDTH(8), .COUNT_W(8), .GUARD(8)) dut_a (
    .clk(clk), .rst(rst), .flush(flush), .bus(ua.slave)
  );
  sum_accumulator #(.BITWIDTH(8), .COUNT_W(8), .GUARD(0)) dut_b (
    .clk(clk), .rst(rst), .flush(flush), .bus(ub.slave)
  );

  task automatic check(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected frame total for an accumulator of width w given the true sum.
  function automatic logic [63:0] model_acc(input longint total, input int w);
    longint lim = longint'(1) << w;
    if (total < lim) return total;
`ifdef SUM_ACC_SATURATE_EN
    return lim - 1;
`else
    return total % lim;
`endif
  endfunction

  typedef struct {
    int         len;
    logic [8:0] s [8];
    logic [63:0] exp_a;
    logic [63:0] exp_b;
    logic       exp_ovf_b;
    int         exp_count;
  } frame_t;

  logic [63:0] last_acc_a, last_acc_b, last_cnt;
  logic        last_ovf_b;

  task automatic run_frame(input int len, input logic [8:0] s [8],
                           input int bubbles, input int stall);
    int eff;
    longint total;
    eff = (len == 0) ? 1 : len;
    total = 0;
    for (int i = 0; i < eff; i++) begin
      int nb;
      nb = (bubbles > 0) ? $urandom_range(0, bubbles) : 0;
      in_valid = 1'b0;
      repeat (nb) tick();
      in_valid = 1'b1;
      {in_carry, in_sum} = s[i];
      in_len = (i == 0) ? 8'(len) : 8'($urandom_range(0, 255));
      total += longint'(s[i]);
      #1;
      check("in_ready_accept", ua.in_ready, 1);
      tick();
    end
    in_valid = 1'b0;
    #1;
    for (int k = 0; k <= stall; k++) begin
      check("out_valid", ua.out_valid, 1);
      check("acc_a", ua.out_acc, model_acc(total, 17));
      check("acc_b", ub.out_acc, model_acc(total, 9));
      check("count", ua.out_count, 64'(eff));
      check("ovf_a", ua.out_ovf, 0);
      check("ovf_b", ub.out_ovf, (total >= 512) ? 1 : 0);
      if (k < stall) begin
        in_valid = 1'b1;
        in_sum = 8'($urandom);
        #1;
        check("in_ready_hold", ua.in_ready, 0);
        tick();
        in_valid = 1'b0;
      end
    end
    last_acc_a = ua.out_acc;
    last_acc_b = ub.out_acc;
    last_cnt   = ua.out_count;
    last_ovf_b = ub.out_ovf;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    #1;
    check("released", ua.out_valid, 0);
    check("cleared", ua.out_acc, 0);
  endtask

  frame_t tbl [4];
  logic [8:0] sv [8];

  initial begin
    tbl[0].len = 4;
    tbl[0].s = '{9'h010, 9'h100, 9'h0FF, 9'h1FF, 0, 0, 0, 0};
    tbl[0].exp_a = 64'h40E;
`ifdef SUM_ACC_SATURATE_EN
    tbl[0].exp_b = 64'h1FF;
`else
    tbl[0].exp_b = 64'h00E;
`endif
    tbl[0].exp_ovf_b = 1'b1;
    tbl[0].exp_count = 4;
    tbl[1].len = 0;
    tbl[1].s = '{9'h101, 0, 0, 0, 0, 0, 0, 0};
    tbl[1].exp_a = 64'h101;
    tbl[1].exp_b = 64'h101;
    tbl[1].exp_ovf_b = 1'b0;
    tbl[1].exp_count = 1;
    tbl[2].len = 3;
    tbl[2].s = '{9'h1FF, 9'h1FF, 9'h1FF, 0, 0, 0, 0, 0};
    tbl[2].exp_a = 64'h5FD;
`ifdef SUM_ACC_SATURATE_EN
    tbl[2].exp_b = 64'h1FF;
`else
    tbl[2].exp_b = 64'h1FD;
`endif
    tbl[2].exp_ovf_b = 1'b1;
    tbl[2].exp_count = 3;
    tbl[3].len = 2;
    tbl[3].s = '{9'h001, 9'h002, 0, 0, 0, 0, 0, 0};
    tbl[3].exp_a = 64'h003;
    tbl[3].exp_b = 64'h003;
    tbl[3].exp_ovf_b = 1'b0;
    tbl[3].exp_count = 2;

    rst = 1'b1;
    flush = 1'b0;
    in_valid = 1'b1;
    in_carry = 1'b1;
    in_sum = 8'h55;
    in_len = 8'd2;
    out_ready = 1'b0;
    for (int c = 0; c < 2; c++) begin
      tick();
      check("rst_in_ready", ua.in_ready, 0);
      check("rst_out_valid", ua.out_valid, 0);
      check("rst_out_acc", ua.out_acc, 0);
      check("rst_out_ovf", ua.out_ovf, 0);
      check("rst_out_count", ua.out_count, 0);
    end
    rst = 1'b0;
    in_valid = 1'b0;
    #1;
    check("idle_in_ready", ua.in_ready, 1);

    for (int t = 0; t < 4; t++) begin
      run_frame(tbl[t].len, tbl[t].s, 0, (t == 0) ? 5 : 0);
      check("tbl_acc_a", last_acc_a, tbl[t].exp_a);
      check("tbl_acc_b", last_acc_b, tbl[t].exp_b);
      check("tbl_ovf_b", last_ovf_b, tbl[t].exp_ovf_b);
      check("tbl_count", last_cnt, 64'(tbl[t].exp_count));
    end

    sv = '{9'h003, 9'h004, 9'h005, 9'h006, 0, 0, 0, 0};
    in_len = 8'd4;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      {in_carry, in_sum} = sv[i];
      tick();
    end
    flush = 1'b1;
    in_valid = 1'b1;
    {in_carry, in_sum} = sv[2];
    #1;
    check("flush_in_ready", ua.in_ready, 0);
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    #1;
    check("flush_out_valid", ua.out_valid, 0);
    check("flush_acc", ua.out_acc, 0);
    check("flush_count", ua.out_count, 0);
    check("flush_idle_ready", ua.in_ready, 1);
    sv = '{9'h005, 0, 0, 0, 0, 0, 0, 0};
    run_frame(1, sv, 0, 0);
    check("post_flush_acc", last_acc_a, 64'h005);
    check("post_flush_cnt", last_cnt, 64'h1);

    sv = '{9'h1FF, 9'h1FF, 9'h1FF, 9'h1FF, 0, 0, 0, 0};
    in_len = 8'd4;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      {in_carry, in_sum} = sv[i];
      tick();
    end
    in_valid = 1'b0;
    #1;
    check("hold_before_flush", ua.out_valid, 1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    #1;
    check("hold_discard", ua.out_valid, 0);
    check("hold_discard_ovf", ub.out_ovf, 0);

    for (int r = 0; r < 25; r++) begin
      int len;
      len = $urandom_range(0, 8);
      for (int i = 0; i < 8; i++) sv[i] = 9'($urandom_range(0, 511));
      run_frame(len, sv, $urandom_range(0, 2), $urandom_range(0, 3));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
